// File: rtl/perceptron_pkg.sv
// Shared widths, class encodings and FSM state type for the perceptron evaluator.
package perceptron_pkg;

    localparam int unsigned XW_DEF = 7;
    localparam int unsigned WW_DEF = 14;
    localparam int unsigned CW_DEF = 10;

    localparam logic [1:0] CLS_POS = 2'b01;
    localparam logic [1:0] CLS_NEG = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/perceptron_dot.sv
// Two-stage signed dot product yin = x1*w1 + x2*w2 + b.
// Stage 1 registers both products. Stage 2 is the final adder, presented
// combinationally so the consumer's result register closes the second stage.
module perceptron_dot
    import perceptron_pkg::*;
#(
    parameter  int unsigned XW = XW_DEF,
    parameter  int unsigned WW = WW_DEF,
    localparam int unsigned PW = XW + WW,
    localparam int unsigned YW = XW + WW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [XW-1:0] x1,
    input  logic signed [XW-1:0] x2,
    input  logic signed [WW-1:0] w1,
    input  logic signed [WW-1:0] w2,
    input  logic signed [WW-1:0] b,
    output logic                 out_valid,
    output logic signed [YW-1:0] yin_c
);

    logic signed [PW-1:0] prod1;
    logic signed [PW-1:0] prod2;

    // Stage 1: register both full-width products and the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            prod1     <= '0;
            prod2     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                prod1 <= PW'(x1) * PW'(w1);
                prod2 <= PW'(x2) * PW'(w2);
            end
        end
    end

    // Stage 2: sign-extended sum plus bias; YW bits cannot overflow.
    assign yin_c = YW'(prod1) + YW'(prod2) + YW'(b);

endmodule

// File: rtl/perceptron_evaluator.sv
// Captures trained weights on start, classifies a stream of test samples,
// and accumulates saturating sample/error counts for the run.
module perceptron_evaluator
    import perceptron_pkg::*;
#(
    parameter int unsigned XW = XW_DEF,
    parameter int unsigned WW = WW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [WW-1:0] w1,
    input  logic signed [WW-1:0] w2,
    input  logic signed [WW-1:0] b,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [XW-1:0] x1,
    input  logic signed [XW-1:0] x2,
    input  logic [1:0]           t,
    input  logic                 s_last,
    output logic                 p_valid,
    output logic [1:0]           p_class,
    output logic                 p_match,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        total_cnt,
    output logic [CW-1:0]        err_cnt
);

    localparam int unsigned YW = XW + WW + 2;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic signed [YW-1:0] YIN_ZERO = '0;

    state_t state;
    state_t next_state;

    logic signed [WW-1:0] w1_q;
    logic signed [WW-1:0] w2_q;
    logic signed [WW-1:0] b_q;
    logic [1:0]           t_q;
    logic                 dot_valid;
    logic signed [YW-1:0] yin_c;
    logic [1:0]           cls_c;
    logic                 accept;
    logic                 start_ok;
    logic                 s_ready_d;
    logic                 busy_d;
    logic                 done_d;

    assign accept   = s_valid & s_ready;
    assign start_ok = start & ((state == IDLE) | (state == DONE));
    assign cls_c    = (yin_c < YIN_ZERO) ? CLS_NEG : CLS_POS;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is honoured only from IDLE or DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start)             next_state = LOAD;
            LOAD:                              next_state = RUN;
            RUN:        if (accept && s_last)  next_state = DRAIN;
            DRAIN:      if (p_valid && !dot_valid) next_state = DONE;
            default:                           next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flops line up with it.
    always_comb begin
        s_ready_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        s_ready_d = (next_state == RUN);
        busy_d    = (next_state == LOAD) || (next_state == RUN) || (next_state == DRAIN);
        done_d    = (state == DRAIN) && (next_state == DONE);
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            s_ready <= s_ready_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Weight capture on accepted start; target rides alongside stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            w1_q <= '0;
            w2_q <= '0;
            b_q  <= '0;
            t_q  <= '0;
        end else begin
            if (start_ok) begin
                w1_q <= w1;
                w2_q <= w2;
                b_q  <= b;
            end
            if (accept) begin
                t_q <= t;
            end
        end
    end

    perceptron_dot #(
        .XW (XW),
        .WW (WW)
    ) u_dot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .x1        (x1),
        .x2        (x2),
        .w1        (w1_q),
        .w2        (w2_q),
        .b         (b_q),
        .out_valid (dot_valid),
        .yin_c     (yin_c)
    );

    // Result register: class and match held until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_class <= 2'b00;
            p_match <= 1'b0;
        end else begin
            p_valid <= dot_valid;
            if (dot_valid) begin
                p_class <= cls_c;
                // cls_c is always a legal code, so illegal targets never match.
                p_match <= (cls_c == t_q);
            end
        end
    end

    // Saturating run counters, cleared when a new run is started.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_cnt <= '0;
            err_cnt   <= '0;
        end else if (start_ok) begin
            total_cnt <= '0;
            err_cnt   <= '0;
        end else if (p_valid) begin
            if (total_cnt != CNT_MAX) begin
                total_cnt <= total_cnt + CW'(1);
            end
            if (!p_match && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_perceptron_evaluator.sv
// Bench for perceptron_evaluator: a cycle-scheduled behavioural model checked
// every cycle against two instances (CW=10 and CW=2), plus literal spot checks.
module tb_perceptron_evaluator;

    localparam int unsigned XW  = 7;
    localparam int unsigned WW  = 14;
    localparam int unsigned CWA = 10;
    localparam int unsigned CWB = 2;
    localparam int NSCHED = 8192;

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_DONE  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic signed [WW-1:0] w1 = '0;
    logic signed [WW-1:0] w2 = '0;
    logic signed [WW-1:0] b = '0;
    logic signed [XW-1:0] x1 = '0;
    logic signed [XW-1:0] x2 = '0;
    logic [1:0] t = 2'b00;

    logic oa_s_ready, oa_p_valid, oa_p_match, oa_busy, oa_done;
    logic [1:0] oa_p_class;
    logic [CWA-1:0] oa_total, oa_err;
    logic ob_s_ready, ob_p_valid, ob_p_match, ob_busy, ob_done;
    logic [1:0] ob_p_class;
    logic [CWB-1:0] ob_total, ob_err;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    perceptron_evaluator #(.XW(XW), .WW(WW), .CW(CWA)) dut_a (
        .clk(clk), .rst(rst), .start(start), .w1(w1), .w2(w2), .b(b),
        .s_valid(s_valid), .s_ready(oa_s_ready), .x1(x1), .x2(x2), .t(t),
        .s_last(s_last), .p_valid(oa_p_valid), .p_class(oa_p_class),
        .p_match(oa_p_match), .busy(oa_busy), .done(oa_done),
        .total_cnt(oa_total), .err_cnt(oa_err)
    );

    perceptron_evaluator #(.XW(XW), .WW(WW), .CW(CWB)) dut_b (
        .clk(clk), .rst(rst), .start(start), .w1(w1), .w2(w2), .b(b),
        .s_valid(s_valid), .s_ready(ob_s_ready), .x1(x1), .x2(x2), .t(t),
        .s_last(s_last), .p_valid(ob_p_valid), .p_class(ob_p_class),
        .p_match(ob_p_match), .busy(ob_busy), .done(ob_done),
        .total_cnt(ob_total), .err_cnt(ob_err)
    );

    // ---------------- behavioural model ----------------
    bit       ev [0:NSCHED-1];
    bit [1:0] ec [0:NSCHED-1];
    bit       em [0:NSCHED-1];
    bit       ed [0:NSCHED-1];
    int cyc = 0;
    int ph = PH_IDLE;
    int cw1 = 0, cw2 = 0, cb = 0, m_yin = 0;
    int mt_a = 0, me_a = 0, mt_b = 0, me_b = 0;
    logic [1:0] m_pclass = 2'b00;

    function automatic int sat_inc(int v, int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    // At each edge: retire the result of the ending cycle, react to inputs,
    // and schedule results two cycles later and done three cycles later.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 3; i++) begin
                ev[cyc + i] = 1'b0;
                ed[cyc + i] = 1'b0;
            end
            ph = PH_IDLE;
            mt_a = 0; me_a = 0; mt_b = 0; me_b = 0;
            m_pclass = 2'b00;
        end else begin
            if (ev[cyc]) begin
                mt_a = sat_inc(mt_a, 1023);
                mt_b = sat_inc(mt_b, 3);
                if (!em[cyc]) begin
                    me_a = sat_inc(me_a, 1023);
                    me_b = sat_inc(me_b, 3);
                end
            end
            case (ph)
                PH_IDLE, PH_DONE: if (start) begin
                    cw1 = int'(w1); cw2 = int'(w2); cb = int'(b);
                    mt_a = 0; me_a = 0; mt_b = 0; me_b = 0;
                    ph = PH_LOAD;
                end
                PH_LOAD: ph = PH_RUN;
                PH_RUN: if (s_valid) begin
                    m_yin = int'(x1) * cw1 + int'(x2) * cw2 + cb;
                    ev[cyc + 2] = 1'b1;
                    ec[cyc + 2] = (m_yin >= 0) ? 2'b01 : 2'b11;
                    em[cyc + 2] = ((m_yin >= 0) ? 2'b01 : 2'b11) == t;
                    if (s_last) begin
                        ph = PH_DRAIN;
                        ed[cyc + 3] = 1'b1;
                    end
                end
                PH_DRAIN: if (ed[cyc + 1]) ph = PH_DONE;
                default: ph = PH_IDLE;
            endcase
            if (ev[cyc + 1]) m_pclass = ec[cyc + 1];
        end
        cyc = cyc + 1;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_dut(string tag, logic sr, logic bz, logic pv, logic [1:0] pc,
                           logic pm, logic dn, logic [31:0] tc, logic [31:0] erc,
                           int mt, int me);
        chk({tag, "_s_ready"}, 32'(sr), 32'(ph == PH_RUN));
        chk({tag, "_busy"}, 32'(bz), 32'(ph == PH_LOAD || ph == PH_RUN || ph == PH_DRAIN));
        chk({tag, "_p_valid"}, 32'(pv), 32'(ev[cyc]));
        chk({tag, "_p_class"}, 32'(pc), 32'(m_pclass));
        if (ev[cyc]) chk({tag, "_p_match"}, 32'(pm), 32'(em[cyc]));
        chk({tag, "_done"}, 32'(dn), 32'(ed[cyc]));
        chk({tag, "_total_cnt"}, tc, 32'(mt));
        chk({tag, "_err_cnt"}, erc, 32'(me));
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp_dut("a", oa_s_ready, oa_busy, oa_p_valid, oa_p_class, oa_p_match,
                    oa_done, 32'(oa_total), 32'(oa_err), mt_a, me_a);
            cmp_dut("b", ob_s_ready, ob_busy, ob_p_valid, ob_p_class, ob_p_match,
                    ob_done, 32'(ob_total), 32'(ob_err), mt_b, me_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(int a, int c, int d);
        w1 = WW'(a); w2 = WW'(c); b = WW'(d);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic send(int a, int c, logic [1:0] tt, logic last);
        x1 = XW'(a); x2 = XW'(c); t = tt; s_last = last;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk_on = 1'b1;
        chk("reset_s_ready", 32'(oa_s_ready), 32'd0);
        chk("reset_busy", 32'(oa_busy), 32'd0);
        chk("reset_p_class", 32'(oa_p_class), 32'd0);
        rst = 1'b0;
        step();

        // Basic classification, latency and done timing.
        begin_run(3, -2, 1);
        chk("t2_s_ready", 32'(oa_s_ready), 32'd1);
        send(4, 5, 2'b01, 1'b1);
        chk("t2_no_early_valid", 32'(oa_p_valid), 32'd0);
        step();
        chk("t2_p_valid", 32'(oa_p_valid), 32'd1);
        chk("t2_p_class", 32'(oa_p_class), 32'd1);
        chk("t2_p_match", 32'(oa_p_match), 32'd1);
        step();
        chk("t2_done", 32'(oa_done), 32'd1);
        chk("t2_total", 32'(oa_total), 32'd1);
        step();

        // yin == 0 classifies as +1.
        begin_run(1, -1, 0);
        send(9, 9, 2'b11, 1'b1);
        step();
        chk("t3_p_class", 32'(oa_p_class), 32'd1);
        chk("t3_p_match", 32'(oa_p_match), 32'd0);
        step();
        chk("t3_err_cnt", 32'(oa_err), 32'd1);
        step();

        // Gapped stream, ignored mid-run start, two wrong targets.
        begin_run(2, 1, -3);
        send(1, 1, 2'b01, 1'b0);
        step();
        send(-2, 0, 2'b01, 1'b0);
        start = 1'b1; w1 = WW'(100);
        step();
        start = 1'b0;
        send(5, -1, 2'b11, 1'b0);
        step();
        step();
        send(-1, -1, 2'b11, 1'b1);
        step();
        chk("t4_done_not_yet", 32'(oa_done), 32'd0);
        step();
        chk("t4_done", 32'(oa_done), 32'd1);
        chk("t4_total", 32'(oa_total), 32'd4);
        chk("t4_err", 32'(oa_err), 32'd2);
        step();

        // Operand and weight extremes.
        begin_run(-8192, -8192, 8191);
        send(-64, -64, 2'b01, 1'b1);
        step();
        chk("t5a_p_class", 32'(oa_p_class), 32'd1);
        step(); step();
        begin_run(8191, 8191, 8191);
        send(-64, -64, 2'b11, 1'b1);
        step();
        chk("t5b_p_class", 32'(oa_p_class), 32'd3);
        chk("t5b_p_match", 32'(oa_p_match), 32'd1);
        step(); step();

        // Saturation with illegal targets on the narrow instance.
        begin_run(1, 1, 0);
        for (int i = 0; i < 5; i++) send(i, -i, 2'b00, i == 4);
        step(); step();
        chk("t6_b_total", 32'(ob_total), 32'd3);
        chk("t6_b_err", 32'(ob_err), 32'd3);
        chk("t6_a_err", 32'(oa_err), 32'd5);
        begin_run(1, 1, 0);
        chk("t6_b_total_cleared", 32'(ob_total), 32'd0);
        chk("t6_a_err_cleared", 32'(oa_err), 32'd0);

        // Reset with a sample in flight.
        send(1, 1, 2'b01, 1'b0);
        rst = 1'b1;
        step();
        chk("t1_p_valid", 32'(oa_p_valid), 32'd0);
        chk("t1_s_ready", 32'(oa_s_ready), 32'd0);
        chk("t1_busy", 32'(oa_busy), 32'd0);
        chk("t1_p_class", 32'(oa_p_class), 32'd0);
        step();
        rst = 1'b0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
